wb_sram: RTL and testbench



---
 rtl/wb_sram.sv | 215 +++++++++++++++++++++
 tb/tb_wb_sram.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram.sv
// wb_sram: Wishbone 32-bit slave to 16-bit async SRAM bridge.
// Each word access becomes one or two half-word SRAM cycles.
module wb_sram #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1,
  parameter int ACK_HOLDOFF = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RECOVER,
    ACK,
    HOLD,
    ABORT
  } state_t;

  state_t state;
  state_t state_nx;

  logic              half;
  logic              half_nx;
  logic [ADDR_W-2:0] adr_r;
  logic [31:0]       dat_r;
  logic              we_r;
  logic [3:0]        sel_r;
  logic [3:0]        cnt;
  logic [15:0]       rd_lo;

  logic              req;
  logic              strobe_done;
  logic              hold_done;
  logic [ADDR_W-2:0] adr_c;
  logic [31:0]       dat_c;
  logic              we_c;
  logic [3:0]        sel_c;
  logic [1:0]        hsel;
  logic [15:0]       hdat;
  logic              unused_adr;

  assign unused_adr = ^{wb_adr_i[31:ADDR_W+1],
                        wb_adr_i[1:0]};

  assign req = wb_cyc_i & wb_stb_i;

  assign strobe_done = cnt == 4'(WAIT_CYCLES - 1);
  assign hold_done   = cnt == 4'(ACK_HOLDOFF - 1);

  // In IDLE the request is taken straight from the bus.
  assign adr_c = (state == IDLE) ?
                 wb_adr_i[ADDR_W:2] : adr_r;
  assign dat_c = (state == IDLE) ? wb_dat_i : dat_r;
  assign we_c  = (state == IDLE) ? wb_we_i  : we_r;
  assign sel_c = (state == IDLE) ? wb_sel_i : sel_r;

  assign hsel = half_nx ? sel_c[3:2] : sel_c[1:0];
  assign hdat = half_nx ? dat_c[31:16] : dat_c[15:0];

  always_comb begin
    state_nx = state;
    half_nx  = half;
    unique case (state)
      IDLE: begin
        if (req) begin
          half_nx  = wb_we_i &
                     (wb_sel_i[1:0] == 2'b00);
          state_nx = (wb_we_i && wb_sel_i == 4'h0) ?
                     ACK : SETUP;
        end
      end
      SETUP: begin
        state_nx = wb_cyc_i ? STROBE : ABORT;
      end
      STROBE: begin
        if (!wb_cyc_i) begin
          state_nx = ABORT;
        end else if (strobe_done) begin
          if (we_r) begin
            state_nx = RECOVER;
          end else if (!half) begin
            state_nx = SETUP;
            half_nx  = 1'b1;
          end else begin
            state_nx = ACK;
          end
        end
      end
      RECOVER: begin
        if (!wb_cyc_i) begin
          state_nx = ABORT;
        end else if (!half &&
                     sel_r[3:2] != 2'b00) begin
          state_nx = SETUP;
          half_nx  = 1'b1;
        end else begin
          state_nx = ACK;
        end
      end
      ACK: begin
        state_nx = (ACK_HOLDOFF == 0) ? IDLE : HOLD;
      end
      HOLD: begin
        if (hold_done) state_nx = IDLE;
      end
      ABORT: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      half     <= 1'b0;
      adr_r    <= '0;
      dat_r    <= '0;
      we_r     <= 1'b0;
      sel_r    <= '0;
      cnt      <= '0;
      rd_lo    <= '0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
    end else begin
      state    <= state_nx;
      half     <= half_nx;
      cnt      <= (state_nx == state) ?
                  cnt + 4'd1 : 4'd0;
      wb_ack_o <= state_nx == ACK;
      if (state == IDLE && req) begin
        adr_r <= wb_adr_i[ADDR_W:2];
        dat_r <= wb_dat_i;
        we_r  <= wb_we_i;
        sel_r <= wb_sel_i;
      end
      // Low half is staged so an aborted read leaves dat_o intact.
      if (state == STROBE && strobe_done &&
          !we_r && wb_cyc_i) begin
        if (half) wb_dat_o <= {sram_dq_i, rd_lo};
        else      rd_lo    <= sram_dq_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
    end else begin
      unique case (state_nx)
        SETUP, STROBE, RECOVER: begin
          sram_addr <= {adr_c, half_nx};
          sram_ce_n <= 1'b0;
          if (we_c) begin
            sram_lb_n  <= ~hsel[0];
            sram_ub_n  <= ~hsel[1];
            sram_dq_oe <= 1'b1;
            sram_dq_o  <= hdat;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= state_nx != STROBE;
          end else begin
            sram_lb_n  <= 1'b0;
            sram_ub_n  <= 1'b0;
            sram_dq_oe <= 1'b0;
            sram_oe_n  <= 1'b0;
            sram_we_n  <= 1'b1;
          end
        end
        ABORT: begin
          sram_ce_n <= 1'b0;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
        end
        default: begin
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram.sv
// tb_wb_sram: directed bench for wb_sram with a behavioural SRAM.
// A second instance with WAIT_CYCLES=3 covers async reset mid-read.
module tb_wb_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;
  logic [3:0]  wb_sel;
  logic [17:0] s_addr;
  logic [15:0] dq_o, dq_i;
  logic        dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;

  logic [31:0] adr3, dat_o3;
  logic        stb3, cyc3, ack3;
  logic [17:0] s_addr3;
  logic [15:0] dq_o3, dq_i3;
  logic        dq_oe3, ce3_n, oe3_n, we3_n, lb3_n, ub3_n;

  logic [15:0] mem  [0:63];
  logic [15:0] mem3 [0:63];

  int checks = 0;
  int passed = 0;
  int ack_cnt, mon_n, we_cnt, viol;
  logic [17:0] mon_first, mon_last;
  logic        mon_lb, mon_ub;

  wb_sram #(
    .ADDR_W(18), .WAIT_CYCLES(1), .ACK_HOLDOFF(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_we_i(wb_we),
    .wb_sel_i(wb_sel), .wb_stb_i(wb_stb),
    .wb_cyc_i(wb_cyc), .wb_ack_o(wb_ack),
    .sram_addr(s_addr), .sram_dq_o(dq_o),
    .sram_dq_i(dq_i), .sram_dq_oe(dq_oe),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n),
    .sram_we_n(we_n), .sram_lb_n(lb_n),
    .sram_ub_n(ub_n)
  );

  wb_sram #(
    .ADDR_W(18), .WAIT_CYCLES(3), .ACK_HOLDOFF(1)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .wb_adr_i(adr3), .wb_dat_i(32'h0),
    .wb_dat_o(dat_o3), .wb_we_i(1'b0),
    .wb_sel_i(4'hF), .wb_stb_i(stb3),
    .wb_cyc_i(cyc3), .wb_ack_o(ack3),
    .sram_addr(s_addr3), .sram_dq_o(dq_o3),
    .sram_dq_i(dq_i3), .sram_dq_oe(dq_oe3),
    .sram_ce_n(ce3_n), .sram_oe_n(oe3_n),
    .sram_we_n(we3_n), .sram_lb_n(lb3_n),
    .sram_ub_n(ub3_n)
  );

  assign dq_i  = (!ce_n && !oe_n) ?
                 mem[s_addr[5:0]] : 16'h0000;
  assign dq_i3 = (!ce3_n && !oe3_n) ?
                 mem3[s_addr3[5:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[s_addr[5:0]][7:0]  = dq_o[7:0];
      if (!ub_n) mem[s_addr[5:0]][15:8] = dq_o[15:8];
    end
  end

  always @(negedge clk) begin
    if (wb_ack) ack_cnt++;
    if (!ce_n) begin
      if (mon_n == 0) mon_first = s_addr;
      mon_last = s_addr;
      mon_n++;
    end
    if (!we_n) begin
      we_cnt++;
      mon_lb = lb_n;
      mon_ub = ub_n;
    end
    if (dq_oe && !oe_n) viol++;
    if (dq_oe3 && !oe3_n) viol++;
  end

  task automatic mon_clr;
    ack_cnt = 0;
    mon_n   = 0;
    we_cnt  = 0;
    mon_lb  = 1'b1;
    mon_ub  = 1'b1;
  endtask

  task automatic bus_req(input logic we,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] s);
    repeat (3) @(posedge clk);
    #1;
    wb_we    = we;
    wb_adr   = a;
    wb_dat_i = d;
    wb_sel   = s;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic bus_idle;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic bus_xfer(input logic we,
                          input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s,
                          output logic [31:0] rd,
                          output int lat);
    bus_req(we, a, d, s);
    wait_ack(lat);
    rd = wb_dat_o;
    bus_idle();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wb_ack, dq_oe, ce_n, oe_n, we_n, lb_n, ub_n}
        !== 7'b0011111)
      $display("FAIL rst_ctrl: got %b want 0011111",
               {wb_ack, dq_oe, ce_n, oe_n, we_n, lb_n, ub_n});
    else passed++;
    checks++;
    if (wb_dat_o !== 32'h0)
      $display("FAIL rst_dat: got %h want 0", wb_dat_o);
    else passed++;
    checks++;
    if ({s_addr, dq_o} !== 34'h0)
      $display("FAIL rst_addr: got %h/%h want 0/0",
               s_addr, dq_o);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_read;
    logic [31:0] rd;
    int lat;
    mon_clr();
    bus_xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, lat);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (lat !== 5)
      $display("FAIL rd_lat: got %0d want 5", lat);
    else passed++;
    checks++;
    if (rd !== 32'h2222_1111)
      $display("FAIL rd_data: got %h want 22221111", rd);
    else passed++;
    checks++;
    if (mon_first !== 18'd4 || mon_last !== 18'd5)
      $display("FAIL rd_addr: got %0d,%0d want 4,5",
               mon_first, mon_last);
    else passed++;
    checks++;
    if (ack_cnt !== 1)
      $display("FAIL rd_ackcnt: got %0d want 1", ack_cnt);
    else passed++;
  endtask

  task automatic test_write_full;
    logic [31:0] rd;
    int lat;
    mon_clr();
    bus_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, lat);
    checks++;
    if (lat !== 7)
      $display("FAIL wr_lat: got %0d want 7", lat);
    else passed++;
    checks++;
    if (we_cnt !== 2)
      $display("FAIL wr_wecnt: got %0d want 2", we_cnt);
    else passed++;
    checks++;
    if ({mem[9], mem[8]} !== 32'hDEAD_BEEF)
      $display("FAIL wr_mem: got %h want deadbeef",
               {mem[9], mem[8]});
    else passed++;
    bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF)
      $display("FAIL wr_readback: got %h want deadbeef", rd);
    else passed++;
  endtask

  task automatic test_write_byte;
    logic [31:0] rd;
    int lat;
    mon_clr();
    bus_xfer(1'b1, 32'h10, 32'h00AB_0000, 4'b0100,
             rd, lat);
    checks++;
    if (lat !== 4)
      $display("FAIL wb_lat: got %0d want 4", lat);
    else passed++;
    checks++;
    if (mon_first !== 18'd9 || mon_last !== 18'd9)
      $display("FAIL wb_addr: got %0d,%0d want 9,9",
               mon_first, mon_last);
    else passed++;
    checks++;
    if ({mon_lb, mon_ub, we_cnt[3:0]} !== 6'b01_0001)
      $display("FAIL wb_lanes: got lb%b ub%b n%0d want lb0 ub1 n1",
               mon_lb, mon_ub, we_cnt);
    else passed++;
    bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, lat);
    checks++;
    if (rd !== 32'hDEAB_BEEF)
      $display("FAIL wb_readback: got %h want deabbeef", rd);
    else passed++;
  endtask

  task automatic test_write_sel0;
    logic [31:0] rd;
    int lat;
    mon_clr();
    bus_xfer(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, lat);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (lat !== 1)
      $display("FAIL sel0_lat: got %0d want 1", lat);
    else passed++;
    checks++;
    if (mon_n !== 0 || {mem[9], mem[8]} !== 32'hDEAB_BEEF)
      $display("FAIL sel0_nocycle: got n%0d mem %h want n0 deabbeef",
               mon_n, {mem[9], mem[8]});
    else passed++;
  endtask

  task automatic test_back_to_back;
    int lat;
    bus_req(1'b0, 32'h8, 32'h0, 4'hF);
    wait_ack(lat);
    @(posedge clk);
    #1;
    mon_clr();
    @(posedge clk);
    #1;
    bus_idle();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (lat !== 5 || mon_n !== 0 || ack_cnt !== 0)
      $display("FAIL hold1: got lat%0d n%0d ack%0d want 5/0/0",
               lat, mon_n, ack_cnt);
    else passed++;
    bus_req(1'b0, 32'h8, 32'h0, 4'hF);
    wait_ack(lat);
    @(posedge clk);
    #1;
    mon_clr();
    repeat (2) @(posedge clk);
    #1;
    bus_idle();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (lat !== 5 || mon_n == 0 || mon_first !== 18'd4)
      $display("FAIL hold2_start: got lat%0d n%0d a%0d want 5/>0/4",
               lat, mon_n, mon_first);
    else passed++;
    checks++;
    if (ack_cnt !== 0)
      $display("FAIL hold2_noack: got %0d want 0", ack_cnt);
    else passed++;
  endtask

  task automatic test_abort;
    mem[16] = 16'hAAAA;
    mem[17] = 16'h5555;
    mon_clr();
    bus_req(1'b1, 32'h20, 32'h1234_5678, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (we_n !== 1'b0)
      $display("FAIL ab_strobe: got we_n %b want 0", we_n);
    else passed++;
    bus_idle();
    @(posedge clk);
    #1;
    checks++;
    if ({we_n, dq_oe, ce_n} !== 3'b110)
      $display("FAIL ab_step1: got %b want 110",
               {we_n, dq_oe, ce_n});
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if ({ce_n, dq_oe} !== 2'b10)
      $display("FAIL ab_step2: got %b want 10",
               {ce_n, dq_oe});
    else passed++;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ack_cnt !== 0 || mem[17] !== 16'h5555)
      $display("FAIL ab_effect: got ack%0d hi %h want 0 5555",
               ack_cnt, mem[17]);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    int lat;
    repeat (3) @(posedge clk);
    #1;
    adr3 = 32'h4;
    cyc3 = 1'b1;
    stb3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ce3_n, oe3_n} !== 2'b00)
      $display("FAIL mid_strobe: got %b want 00",
               {ce3_n, oe3_n});
    else passed++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack3, dq_oe3, ce3_n, oe3_n, we3_n, lb3_n, ub3_n}
        !== 7'b0011111 || s_addr3 !== 18'd0)
      $display("FAIL mid_rst: got %b a%0d want 0011111 a0",
               {ack3, dq_oe3, ce3_n, oe3_n, we3_n, lb3_n, ub3_n},
               s_addr3);
    else passed++;
    cyc3 = 1'b0;
    stb3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cyc3 = 1'b1;
    stb3 = 1'b1;
    lat  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (ack3) begin
        lat = i;
        break;
      end
    end
    rd   = dat_o3;
    cyc3 = 1'b0;
    stb3 = 1'b0;
    checks++;
    if (lat !== 9 || rd !== 32'h4444_3333)
      $display("FAIL post_rst3: got lat%0d %h want 9 44443333",
               lat, rd);
    else passed++;
    bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, lat);
    checks++;
    if (lat !== 5 || rd !== 32'hDEAB_BEEF)
      $display("FAIL post_rst1: got lat%0d %h want 5 deabbeef",
               lat, rd);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    wb_adr   = '0;
    wb_dat_i = '0;
    wb_we    = 1'b0;
    wb_sel   = '0;
    wb_stb   = 1'b0;
    wb_cyc   = 1'b0;
    adr3     = '0;
    stb3     = 1'b0;
    cyc3     = 1'b0;
    viol     = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i]  = 16'h0;
      mem3[i] = 16'h0;
    end
    mem[4]  = 16'h1111;
    mem[5]  = 16'h2222;
    mem3[2] = 16'h3333;
    mem3[3] = 16'h4444;
    mon_clr();
    test_reset();
    test_read();
    test_write_full();
    test_write_byte();
    test_write_sel0();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    checks++;
    if (viol !== 0)
      $display("FAIL oe_contention: got %0d want 0", viol);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
